// File: rtl/ex_gcd_gcd_client.sv
// GCD requester: LFSR operand pairs, <=p_max_outstanding in flight, checksum of results; outputs are registered-state only.
// Latency: first req_val the cycle after cfg go, 1 req/cycle; stalls on req_rdy or full window. Optional EX_GCD_CLIENT_PERF_EN adds cycle_count_o.
module ex_gcd_gcd_client #(
  parameter int p_nbits           = 16,
  parameter int p_max_outstanding = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_val_i,
  output logic                 cfg_rdy_o,
  input  logic [15:0]          cfg_count_i,
  input  logic [p_nbits-1:0]   cfg_seed_i,
  output logic                 req_val_o,
  input  logic                 req_rdy_i,
  output logic [2*p_nbits-1:0] req_msg_o,
  input  logic                 resp_val_i,
  output logic                 resp_rdy_o,
  input  logic [p_nbits-1:0]   resp_msg_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [p_nbits-1:0]   checksum_o
`ifdef EX_GCD_CLIENT_PERF_EN
  ,
  output logic [31:0]          cycle_count_o
`endif
);

  localparam int OW = $clog2(p_max_outstanding + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(p_max_outstanding);
  localparam logic [p_nbits-1:0] POLY = p_nbits'(16'hB400);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [p_nbits-1:0] lfsr_q, lfsr_d;
  logic [15:0]        count_q, count_d;
  logic [15:0]        sent_q, sent_d;
  logic [15:0]        recv_q, recv_d;
  logic [OW-1:0]      outs_q, outs_d;
  logic [p_nbits-1:0] checksum_q, checksum_d;
  logic               cfg_go, req_go, resp_go;

  function automatic logic [p_nbits-1:0] step(input logic [p_nbits-1:0] s);
    return (s >> 1) ^ (s[0] ? POLY : '0);
  endfunction

  assign cfg_rdy_o  = (state_q != S_RUN);
  assign req_val_o  = (state_q == S_RUN) && (sent_q < count_q) && (outs_q < MAX_OUT);
  assign resp_rdy_o = (state_q == S_RUN) && (outs_q != '0);
  assign req_msg_o  = {lfsr_q, step(lfsr_q)};
  assign busy_o     = (state_q == S_RUN);
  assign done_o     = (state_q == S_DONE);
  assign checksum_o = checksum_q;

  assign cfg_go  = cfg_val_i && cfg_rdy_o;
  assign req_go  = req_val_o && req_rdy_i;
  assign resp_go = resp_val_i && resp_rdy_o;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    count_d    = count_q;
    sent_d     = sent_q;
    recv_d     = recv_q;
    outs_d     = outs_q;
    checksum_d = checksum_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_go) begin
          count_d    = cfg_count_i;
          lfsr_d     = (cfg_seed_i == '0) ? p_nbits'(1) : cfg_seed_i;
          sent_d     = '0;
          recv_d     = '0;
          outs_d     = '0;
          checksum_d = '0;
          state_d    = (cfg_count_i == 16'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Each request consumes two LFSR steps: one per operand.
        if (req_go) begin
          lfsr_d = step(step(lfsr_q));
          sent_d = sent_q + 16'd1;
        end
        if (resp_go) begin
          checksum_d = checksum_q + resp_msg_i;
          recv_d     = recv_q + 16'd1;
          if (recv_d == count_q) state_d = S_DONE;
        end
        if (req_go && !resp_go)      outs_d = outs_q + OW'(1);
        else if (!req_go && resp_go) outs_d = outs_q - OW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lfsr_q     <= p_nbits'(1);
      count_q    <= '0;
      sent_q     <= '0;
      recv_q     <= '0;
      outs_q     <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      count_q    <= count_d;
      sent_q     <= sent_d;
      recv_q     <= recv_d;
      outs_q     <= outs_d;
      checksum_q <= checksum_d;
    end
  end

`ifdef EX_GCD_CLIENT_PERF_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (cfg_go)                                    cyc_d = '0;
    else if ((state_q == S_RUN) && (cyc_q != '1)) cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign cycle_count_o = cyc_q;
`endif

`ifndef SYNTHESIS
  a_handshake_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown({req_val_o, req_rdy_i, resp_val_i, resp_rdy_o}));
  a_resp_without_req: assert property (@(posedge clk) disable iff (reset)
    ((state_q == S_RUN) && resp_val_i) |-> (outs_q != '0));
`endif

endmodule

// File: tb/tb_ex_gcd_gcd_client.sv
// Scoreboarded bench for ex_gcd_gcd_client: reference model of LFSR pairs and Euclid GCD, randomized responder.
module tb_ex_gcd_gcd_client;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_val_i = 1'b0;
  logic        cfg_rdy_o;
  logic [15:0] cfg_count_i = '0;
  logic [15:0] cfg_seed_i = '0;
  logic        req_val_o;
  logic        req_rdy_i = 1'b0;
  logic [31:0] req_msg_o;
  logic        resp_val_i = 1'b0;
  logic        resp_rdy_o;
  logic [15:0] resp_msg_i = '0;
  logic        busy_o, done_o;
  logic [15:0] checksum_o;
`ifdef EX_GCD_CLIENT_PERF_EN
  logic [31:0] cycle_count_o;
`endif

  ex_gcd_gcd_client #(.p_nbits(16), .p_max_outstanding(MAXO)) dut (
    .clk(clk), .reset(reset),
    .cfg_val_i(cfg_val_i), .cfg_rdy_o(cfg_rdy_o), .cfg_count_i(cfg_count_i), .cfg_seed_i(cfg_seed_i),
    .req_val_o(req_val_o), .req_rdy_i(req_rdy_i), .req_msg_o(req_msg_o),
    .resp_val_i(resp_val_i), .resp_rdy_o(resp_rdy_o), .resp_msg_i(resp_msg_i),
    .busy_o(busy_o), .done_o(done_o), .checksum_o(checksum_o)
`ifdef EX_GCD_CLIENT_PERF_EN
    , .cycle_count_o(cycle_count_o)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [15:0] pend_q[$];
  logic [15:0] exp_sum = '0;
  int  rdy_pct = 100;
  bit  stall_resp = 1'b0;
  int  req_limit = 1 << 30;
  int  acc_total = 0;
  int  out_cnt = 0;
  int  max_out = 0;
  int  run_cyc = 0;
  bit  prev_stalled = 1'b0;
  logic [31:0] prev_msg = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference model: plain-arithmetic LFSR and Euclid GCD.
  function automatic logic [15:0] m_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] m_gcd(input logic [15:0] a, input logic [15:0] b);
    int x = a;
    int y = b;
    while (y != 0) begin
      int t = x % y;
      x = y;
      y = t;
    end
    return x[15:0];
  endfunction

  task automatic issue(input logic [15:0] count, input logic [15:0] seed);
    logic [15:0] s, a, b;
    s = (seed == 16'd0) ? 16'd1 : seed;
    exp_sum = '0;
    for (int i = 0; i < int'(count); i++) begin
      a = s;
      b = m_step(s);
      exp_q.push_back({a, b});
      exp_sum = exp_sum + m_gcd(a, b);
      s = m_step(b);
    end
    @(posedge clk); #2;
    run_cyc = 0;
    acc_total = 0;
    max_out = 0;
    chk("cfg_rdy_before_go", {31'd0, cfg_rdy_o}, 32'd1);
    cfg_val_i = 1'b1;
    cfg_count_i = count;
    cfg_seed_i = seed;
    @(posedge clk); #2;
    cfg_val_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done_o && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    vectors++;
    if (done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout: done=%b expected 1", name, done_o);
    end
  endtask

  task automatic end_of_run(input string name, input logic [15:0] sum);
    chk({name, "_checksum"}, {16'd0, checksum_o}, {16'd0, sum});
    chk({name, "_reqs_left"}, exp_q.size(), 32'd0);
    chk({name, "_max_out_le2"}, {31'd0, (max_out <= MAXO)}, 32'd1);
`ifdef EX_GCD_CLIENT_PERF_EN
    chk({name, "_cycle_count"}, cycle_count_o, run_cyc);
`endif
  endtask

  // Responder and monitor: drives GCD-unit side at negedge, checks transfers before the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        req_rdy_i = 1'b0;
        resp_val_i = 1'b0;
        resp_msg_i = '0;
        pend_q.delete();
        out_cnt = 0;
        prev_stalled = 1'b0;
        continue;
      end
      req_rdy_i  = (acc_total < req_limit) && ($urandom_range(1, 100) <= rdy_pct);
      resp_val_i = !stall_resp && (pend_q.size() > 0) && ($urandom_range(1, 100) <= rdy_pct);
      resp_msg_i = (pend_q.size() > 0) ? pend_q[0] : 16'h0000;
      #1;
      if (busy_o) run_cyc++;
      chk("resp_rdy", {31'd0, resp_rdy_o}, {31'd0, (busy_o && out_cnt > 0)});
      chk("req_val", {31'd0, req_val_o}, {31'd0, (busy_o && exp_q.size() > 0 && out_cnt < MAXO)});
      if (prev_stalled) chk("req_msg_stable", req_msg_o, prev_msg);
      if (req_val_o && req_rdy_i) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_req: got %h expected no request", req_msg_o);
        end else begin
          chk("req_msg", req_msg_o, exp_q.pop_front());
        end
        pend_q.push_back(m_gcd(req_msg_o[31:16], req_msg_o[15:0]));
        acc_total++;
        out_cnt++;
      end
      if (resp_val_i && resp_rdy_o) begin
        void'(pend_q.pop_front());
        out_cnt--;
      end
      if (out_cnt > max_out) max_out = out_cnt;
      prev_stalled = req_val_o && !req_rdy_i;
      prev_msg = req_msg_o;
    end
  end

  initial begin
    // T1: reset values after two reset cycles
    repeat (2) @(posedge clk);
    #2;
    chk("rst_cfg_rdy", {31'd0, cfg_rdy_o}, 32'd1);
    chk("rst_req_val", {31'd0, req_val_o}, 32'd0);
    chk("rst_resp_rdy", {31'd0, resp_rdy_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_checksum", {16'd0, checksum_o}, 32'd0);
    reset = 1'b0;

    // T2: ideal responder, seed 1, two requests
    issue(16'd2, 16'd1);
    chk("t2_busy", {31'd0, busy_o}, 32'd1);
    wait_done("t2");
    chk("t2_checksum_const", {16'd0, checksum_o}, 32'h2D01);
    end_of_run("t2", exp_sum);

    // T3: count 0 goes straight to DONE
    issue(16'd0, 16'h1234);
    chk("t3_done", {31'd0, done_o}, 32'd1);
    chk("t3_busy", {31'd0, busy_o}, 32'd0);
    repeat (5) @(posedge clk);
    #2;
    end_of_run("t3", 16'h0000);

    // T4: seed 0 behaves as seed 1
    issue(16'd1, 16'd0);
    wait_done("t4");
    end_of_run("t4", exp_sum);

    // T5: responses stalled, window must cap at two
    stall_resp = 1'b1;
    issue(16'd4, 16'hACE1);
    repeat (10) @(posedge clk);
    #2;
    chk("t5_reqs_sent", acc_total, 32'd2);
    chk("t5_req_val_low", {31'd0, req_val_o}, 32'd0);
    chk("t5_max_out", max_out, 32'd2);
    stall_resp = 1'b0;
    wait_done("t5");
    end_of_run("t5", exp_sum);

    // T6: reset mid-RUN after one accepted request
    req_limit = 1;
    issue(16'd4, 16'd1);
    begin
      int n = 0;
      while (acc_total < 1 && n < 100) begin
        @(posedge clk); #2;
        n++;
      end
    end
    chk("t6_one_req", acc_total, 32'd1);
    chk("t6_busy_before_rst", {31'd0, busy_o}, 32'd1);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #2;
    chk("t6_cfg_rdy", {31'd0, cfg_rdy_o}, 32'd1);
    chk("t6_req_val", {31'd0, req_val_o}, 32'd0);
    chk("t6_resp_rdy", {31'd0, resp_rdy_o}, 32'd0);
    chk("t6_busy", {31'd0, busy_o}, 32'd0);
    chk("t6_done", {31'd0, done_o}, 32'd0);
    chk("t6_checksum", {16'd0, checksum_o}, 32'd0);
`ifdef EX_GCD_CLIENT_PERF_EN
    chk("t6_cycle_count", cycle_count_o, 32'd0);
`endif
    @(posedge clk); #2;
    reset = 1'b0;
    req_limit = 1 << 30;
    issue(16'd2, 16'd1);
    wait_done("t6_rerun");
    chk("t6_checksum_const", {16'd0, checksum_o}, 32'h2D01);
    end_of_run("t6_rerun", exp_sum);

    // Randomized runs with random handshake throttling
    for (int r = 0; r < 8; r++) begin
      rdy_pct = $urandom_range(30, 100);
      issue(16'($urandom_range(1, 20)), 16'($urandom));
      wait_done("rand");
      end_of_run("rand", exp_sum);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
